replay_unpacker: RTL
====================

// Module: replay_unpacker
// PURPOSE
//  Decompression end of the multiplexed column: undoes the 2:1 time compression applied to input spikes.
//  The shared column emits compressed output spikes for virtual column 1 while grst=0 and for virtual column 2 while grst=1.
//  Each phase's compressed slots are captured into a ping-pong store.
//  In the next frame they are replayed at original timing on two per-column output buses.
//  Frame = one grst-low phase followed by one grst-high phase.
// PARAMETERS
//  BUFFER_DEPTH  16  expanded gamma window in cycles; even, >=4; compressed slots per phase = BUFFER_DEPTH/2
//  Q             16  column output width (neurons per virtual column)
// PORTS
//  clk          in   1               clock
//  rst          in   1               asynchronous reset, active-high
//  grst         in   1               gamma phase; 0 = column 1 phase, 1 = column 2 phase; sampled on clk
//  start_count  in   1               compressed slot valid; advances write slot
//  data_in      in   Q               compressed spike vector from shared column
//  data_out1    out  Q               expanded spikes, virtual column 1 (registered)
//  data_out2    out  Q               expanded spikes, virtual column 2 (registered)
//  out_valid    out  1               replay bank holds a complete captured frame
//  ovf          out  1               sticky slot overflow (UNPACK_OVF_EN only)
// BEHAVIOUR
//  - Reset (async): all store bits 0; wb=0; wr_slot=0; rd_t=0; grst_q=0; data_out1/2=0; out_valid=0; ovf=0.
//  - Edge detect: rise = grst&~grst_q, fall = ~grst&grst_q. Both act in the cycle grst first reads new level.
//  - Store: mem[bank 0..1][col 0..1][slot 0..BUFFER_DEPTH/2-1], Q bits each.
//    - Write bank = wb; read bank = ~wb; col = grst.
//  - Write slot counter wr_slot:
//    - Forced to 0 on any grst edge and whenever start_count=0.
//    - When start_count=1 and wr_slot<BUFFER_DEPTH/2: write mem[wb][grst][wr_slot] <= data_in, then wr_slot++.
//    - wr_slot saturates at BUFFER_DEPTH/2 (done); further start_count=1 cycles are dropped, set ovf.
//  - Frame swap, on fall:
//    - wb toggles.
//    - The new write bank (both cols) is cleared.
//    - A slot-0 write in the same cycle lands after the clear: write wins.
//    - rd_t <= 0.
//    - out_valid <= 1 from the first fall after reset; stays 1.
//  - Replay counter rd_t:
//    - Increments each cycle after a fall, saturating at BUFFER_DEPTH.
//    - At rd_t==BUFFER_DEPTH, outputs are 0 until the next fall.
//  - Expansion (registered, 1-cycle latency from rd_t):
//    - rd_t even: data_out1 <= mem[~wb][0][rd_t/2], data_out2 <= mem[~wb][1][rd_t/2].
//    - rd_t odd: data_out1/2 <= 0 (compressed slot k maps to original time 2k).
//    - out_valid=0: data_out1/2 <= 0.
//  - rise: no bank swap, no rd_t effect; only restarts wr_slot for col 2.
//  - grst glitch shorter than one clk is not seen.
//  - Back-to-back edges each restart wr_slot per rules above.
//  - Reset mid-frame: immediate return to reset state; the first replay after reset needs a full frame.
// CONFIGURATION
//  UNPACK_OVF_EN defined:
//    - ovf port present.
//    - Set by a dropped write (start_count=1 at wr_slot==BUFFER_DEPTH/2); sticky until rst.
//  UNPACK_OVF_EN undefined:
//    - ovf port and logic absent.
//    - Dropped writes are silently discarded; all other behaviour identical.
// TESTING (BUFFER_DEPTH=16, Q=4)
//  1. rst=1 then release, grst=0, no start_count -> data_out1/2=0, out_valid=0, ovf=0.
//  2. Capture and replay:
//     - Stimulus: phase0 data_in=slot k -> 4'h1<<(k%4), 8 slots; phase1 data_in=4'hF on slot 3 only; then grst falls.
//     - Response: out_valid=1.
//     - data_out1 = 1,0,2,0,4,0,8,0,... on rd_t=0..15 (1-cycle latency).
//     - data_out2 = 4'hF at rd_t=6 only.
//  3. Stale clear: next frame, no start_count -> following frame replays all zeros on both outputs.
//  4. Overflow: 10 consecutive start_count cycles in one phase -> slots 0..7 stored, 2 dropped, ovf=1 and sticky.
//  5. Same-cycle swap write: start_count=1, data_in=4'hA in the fall cycle -> slot 0 of new bank =4'hA, rest 0.
//  6. Reset mid-frame: rst pulse at rd_t=5 -> outputs 0 next cycle, out_valid=0 until a full frame completes.

Source files
------------

// File: rtl/replay_unpacker.sv
// Captures 2:1 time-compressed spikes per grst phase into a ping-pong store and replays them
// at original timing one frame later. Optional sticky overflow flag: define UNPACK_OVF_EN.
module replay_unpacker #(
  parameter int BUFFER_DEPTH = 16,
  parameter int Q            = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         grst,
  input  logic         start_count,
  input  logic [Q-1:0] data_in,
  output logic [Q-1:0] data_out1,
  output logic [Q-1:0] data_out2,
  output logic         out_valid
`ifdef UNPACK_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int HALF = BUFFER_DEPTH / 2;
  localparam int SW   = $clog2(HALF);
  localparam int WW   = $clog2(HALF + 1);
  localparam int RW   = $clog2(BUFFER_DEPTH + 1);
  localparam logic [WW-1:0] HALF_W  = WW'(HALF);
  localparam logic [RW-1:0] DEPTH_R = RW'(BUFFER_DEPTH);

  logic [Q-1:0]  mem_q [2][2][HALF];
  logic          grst_q;
  logic          wb_q, wb_d;
  logic [WW-1:0] wr_slot_q, wr_slot_d, slot_eff;
  logic [RW-1:0] rd_t_q, rd_t_d;
  logic          out_valid_q, out_valid_d;
  logic [Q-1:0]  out1_q, out1_d, out2_q, out2_d;
  logic          rise, fall, wr_en;

  always_comb begin
    rise        = grst & ~grst_q;
    fall        = ~grst & grst_q;
    wb_d        = wb_q ^ fall;
    // Any phase edge restarts capture at slot 0 in the same cycle.
    slot_eff    = (rise | fall) ? '0 : wr_slot_q;
    wr_en       = start_count && (slot_eff < HALF_W);
    wr_slot_d   = '0;
    if (start_count)
      wr_slot_d = wr_en ? slot_eff + WW'(1) : slot_eff;
    rd_t_d      = fall ? '0 : ((rd_t_q == DEPTH_R) ? rd_t_q : rd_t_q + RW'(1));
    out_valid_d = out_valid_q | fall;
    out1_d      = '0;
    out2_d      = '0;
    // Compressed slot k replays at original time 2k; odd times stay silent.
    if (out_valid_q && (rd_t_q != DEPTH_R) && !rd_t_q[0]) begin
      out1_d = mem_q[~wb_q][0][rd_t_q[SW:1]];
      out2_d = mem_q[~wb_q][1][rd_t_q[SW:1]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grst_q      <= 1'b0;
      wb_q        <= 1'b0;
      wr_slot_q   <= '0;
      rd_t_q      <= '0;
      out_valid_q <= 1'b0;
      out1_q      <= '0;
      out2_q      <= '0;
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 2; c++)
          for (int s = 0; s < HALF; s++)
            mem_q[b][c][s] <= '0;
    end else begin
      grst_q      <= grst;
      wb_q        <= wb_d;
      wr_slot_q   <= wr_slot_d;
      rd_t_q      <= rd_t_d;
      out_valid_q <= out_valid_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      if (fall)
        for (int c = 0; c < 2; c++)
          for (int s = 0; s < HALF; s++)
            mem_q[wb_d][c][s] <= '0;
      // Placed after the clear so a slot-0 write in the swap cycle survives.
      if (wr_en)
        mem_q[wb_d][grst][slot_eff[SW-1:0]] <= data_in;
    end
  end

  assign data_out1 = out1_q;
  assign data_out2 = out2_q;
  assign out_valid = out_valid_q;

`ifdef UNPACK_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (start_count && !wr_en)
      ovf_q <= 1'b1;
  end
  assign ovf = ovf_q;
`endif

endmodule
